// File: rtl/apb_timer_cmd_master_if.sv
// Signal bundle for apb_timer_cmd_master: command port, response port
// and the APB requester bus toward the timer slave.
interface apb_timer_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_timer_cmd_master.sv
// APB requester for the timer slave: queues register commands in a FIFO,
// issues them as two-phase APB transfers with a wait-state watchdog.
module apb_timer_cmd_master #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   presetn,
    apb_timer_cmd_master_if.master bus,
    output logic                   busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);

    typedef struct packed {
        logic        write;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    cmd_t          mem [DEPTH];
    cmd_t          cmd_in;
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_d;
    logic [CW-1:0] cnt_inc;

    logic          psel_q,      psel_d;
    logic          penable_q,   penable_d;
    logic          pwrite_q,    pwrite_d;
    logic [9:0]    paddr_q,     paddr_d;
    logic [31:0]   pwdata_q,    pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q,   rsp_err_d;
    logic          rsp_tmo_q,   rsp_tmo_d;

    assign cmd_in = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    assign head   = mem[rd_ptr];
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign push   = bus.cmd_valid && !full;

    assign bus.cmd_ready   = !full;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_tmo_q;

    assign busy = !empty || (state != IDLE) || rsp_valid_q;

    // FIFO storage; contents need no reset since occupancy gates reads
    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Transfer FSM next state, APB outputs and response slot
    always_comb begin
        state_d     = state;
        wait_cnt_d  = wait_cnt;
        cnt_inc     = wait_cnt + 1'b1;
        pop         = 1'b0;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        unique case (state)
            IDLE: begin
                if (!empty && (!rsp_valid_q || bus.rsp_ready)) begin
                    pop        = 1'b1;
                    state_d    = SETUP;
                    wait_cnt_d = '0;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    paddr_d    = head.addr;
                    pwrite_d   = head.write;
                    pwdata_d   = head.write ? head.wdata : 32'h0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? 32'h0 : bus.prdata;
                    rsp_err_d   = bus.pslverr;
                    rsp_tmo_d   = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt_inc == TMO)) begin
                    state_d     = IDLE;
                    wait_cnt_d  = cnt_inc;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                end else begin
                    wait_cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, APB output and response registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end
endmodule

// File: tb/tb_apb_timer_cmd_master.sv
// Bench for apb_timer_cmd_master: APB slave model, response scoreboard,
// vector table plus hand sequences for latency, stall, watchdog and reset.
module tb_apb_timer_cmd_master;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic        write;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    typedef struct {
        logic        write;
        logic [9:0]  addr;
        logic [31:0] pwdata;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
    } slv_t;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    logic busy;

    apb_timer_cmd_master_if bus();

    apb_timer_cmd_master #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 pclk = ~pclk;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];
    slv_t slv_q[$];
    vec_t vecs[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Response scoreboard: compare each handshaked response with the queue head
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge pclk);
            if (presetn && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rdata=%08h err=%0b with none expected",
                             bus.rsp_rdata, bus.rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    chk32("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk1("rsp_err", bus.rsp_err, e.err);
                    chk1("rsp_timeout", bus.rsp_timeout, e.tmo);
                end
            end
        end
    end

    // APB slave model with per-transfer wait states and protocol checks
    initial begin : slave
        slv_t cur;
        int   wcnt;
        logic prev_psel;
        bus.pready  = 1'b0;
        bus.prdata  = 32'h0;
        bus.pslverr = 1'b0;
        wcnt        = 0;
        prev_psel   = 1'b0;
        cur         = '{1'b0, 10'h0, 32'h0, 0, 32'h0, 1'b0};
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                bus.pready = 1'b0;
                prev_psel  = 1'b0;
            end else if (bus.psel && !bus.penable) begin
                chk1("idle_gap_before_setup", prev_psel, 1'b0);
                if (slv_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL apb_unexpected: got transfer to %03h with none expected",
                             bus.paddr);
                end else begin
                    cur = slv_q.pop_front();
                    chk32("setup_paddr", 32'(bus.paddr), 32'(cur.addr));
                    chk1("setup_pwrite", bus.pwrite, cur.write);
                    chk32("setup_pwdata", bus.pwdata, cur.pwdata);
                end
                wcnt        = 0;
                bus.pready  = 1'b0;
                bus.prdata  = $urandom;
                bus.pslverr = 1'($urandom_range(0, 1));
            end else if (bus.psel && bus.penable) begin
                chk32("access_paddr", 32'(bus.paddr), 32'(cur.addr));
                chk1("access_pwrite", bus.pwrite, cur.write);
                chk32("access_pwdata", bus.pwdata, cur.pwdata);
                if (wcnt < cur.waits) begin
                    wcnt++;
                    bus.pready  = 1'b0;
                    bus.prdata  = $urandom;
                    bus.pslverr = 1'($urandom_range(0, 1));
                end else begin
                    bus.pready  = 1'b1;
                    bus.prdata  = cur.rdata;
                    bus.pslverr = cur.slverr;
                end
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
                bus.prdata  = $urandom;
            end
            prev_psel = bus.psel;
        end
    end

    task automatic expect_cmd(input logic w, input logic [9:0] a, input logic [31:0] d,
                              input int waits, input logic [31:0] rd, input logic se,
                              input logic [31:0] er, input logic ee, input logic et);
        slv_t s;
        rsp_t r;
        s.write  = w;
        s.addr   = a;
        s.pwdata = w ? d : 32'h0;
        s.waits  = waits;
        s.rdata  = rd;
        s.slverr = se;
        r.rdata  = er;
        r.err    = ee;
        r.tmo    = et;
        slv_q.push_back(s);
        exp_q.push_back(r);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic drive(input logic w, input logic [9:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, input logic se,
                         input logic [31:0] er, input logic ee, input logic et);
        int n;
        bit done;
        expect_cmd(w, a, d, waits, rd, se, er, ee, et);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        n    = 0;
        done = 0;
        while (!done) begin
            @(negedge pclk);
            if (bus.cmd_ready) done = 1;
            @(posedge pclk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("FAIL cmd_accept: got no cmd_ready within %0d cycles", n);
                done = 1;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            @(posedge pclk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s: got %0d responses outstanding busy=%0b after %0d cycles, expected 0",
                     name, exp_q.size(), busy, n);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int  n_acc;
        int  n;
        int  seen;
        bit  started;
        bit  done;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 10'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;

        vecs[0] = '{1'b1, 10'h000, 32'h0000_0007, 0,  32'h0000_1234, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b0, 10'h001, 32'h1111_1111, 3,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 10'h3FF, 32'hFFFF_FFFF, 0,  32'h9999_9999, 1'b1, 32'h0,         1'b1, 1'b0};
        vecs[3] = '{1'b0, 10'h155, 32'h2222_2222, 0,  32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 10'h2AA, 32'h3333_3333, 15, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 10'h010, 32'h0000_0055, 16, 32'h7777_7777, 1'b0, 32'h0,         1'b1, 1'b1};
        vecs[6] = '{1'b0, 10'h020, 32'h4444_4444, 40, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1, 1'b1};
        vecs[7] = '{1'b0, 10'h0AB, 32'h5555_5555, 1,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0};

        // reset values
        repeat (2) @(negedge pclk);
        chk1("rst_psel", bus.psel, 1'b0);
        chk1("rst_penable", bus.penable, 1'b0);
        chk1("rst_pwrite", bus.pwrite, 1'b0);
        chk32("rst_paddr", 32'(bus.paddr), 32'h0);
        chk32("rst_pwdata", bus.pwdata, 32'h0);
        chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk1("rst_rsp_err", bus.rsp_err, 1'b0);
        chk1("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
        chk32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge pclk);
        #1;
        presetn       = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge pclk);
        #1;

        // latency of a single write with pready tied high
        expect_cmd(1'b1, 10'h000, 32'h7, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 10'h000;
        bus.cmd_wdata = 32'h7;
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        chk1("lat_e0_psel", bus.psel, 1'b0);
        @(negedge pclk);
        chk1("lat_e1_psel", bus.psel, 1'b1);
        chk1("lat_e1_penable", bus.penable, 1'b0);
        @(negedge pclk);
        chk1("lat_e2_psel", bus.psel, 1'b1);
        chk1("lat_e2_penable", bus.penable, 1'b1);
        chk32("lat_e2_pwdata", bus.pwdata, 32'h7);
        @(negedge pclk);
        chk1("lat_e3_rsp_valid", bus.rsp_valid, 1'b1);
        chk1("lat_e3_psel", bus.psel, 1'b0);
        chk1("lat_e3_penable", bus.penable, 1'b0);
        @(posedge pclk);
        #1;
        drain("lat_drain", 50);

        // vector table streamed through the FIFO
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                  vecs[i].rdata, vecs[i].slverr,
                  vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_tmo);
        end
        drain("table_drain", 1000);

        // full FIFO with the response slot blocked
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 10'(10'h100 + i), 32'hFFFF_0000, i % 2, 32'h5000_0000 + i,
                  1'b0, 32'h5000_0000 + i, 1'b0, 1'b0);
        end
        @(negedge pclk);
        chk1("full_cmd_ready", bus.cmd_ready, 1'b0);
        chk1("full_busy", busy, 1'b1);
        chk1("full_rsp_valid", bus.rsp_valid, 1'b1);
        chk32("full_rsp_rdata", bus.rsp_rdata, 32'h5000_0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            chk1("stall_psel", bus.psel, 1'b0);
            chk1("stall_rsp_valid", bus.rsp_valid, 1'b1);
        end
        @(posedge pclk);
        #1;
        bus.rsp_ready = 1'b1;
        drain("full_drain", 200);

        // watchdog abort: count ACCESS cycles before psel drops
        drive(1'b1, 10'h040, 32'h0000_0055, 1000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        n_acc   = 0;
        n       = 0;
        started = 0;
        done    = 0;
        while (!done && n < 100) begin
            @(negedge pclk);
            n++;
            if (bus.psel && bus.penable) begin
                n_acc++;
                started = 1;
            end else if (started) begin
                done = 1;
            end
        end
        chk32("tmo_access_cycles", 32'(n_acc), 32'd16);
        @(posedge pclk);
        #1;
        drive(1'b0, 10'h041, 32'h0, 2, 32'h600D_0001, 1'b0, 32'h600D_0001, 1'b0, 1'b0);
        drain("tmo_next_drain", 100);

        // reset during an ACCESS wait state with two commands queued
        drive(1'b0, 10'h0F0, 32'h0, 1000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        drive(1'b1, 10'h0F1, 32'hAAAA_0001, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 10'h0F2, 32'hAAAA_0002, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (!(bus.psel && bus.penable) && n < 20) begin
            @(negedge pclk);
            n++;
        end
        repeat (3) @(negedge pclk);
        chk1("pre_rst_penable", bus.penable, 1'b1);
        #2;
        presetn = 1'b0;
        #1;
        chk1("async_rst_psel", bus.psel, 1'b0);
        chk1("async_rst_penable", bus.penable, 1'b0);
        chk1("async_rst_cmd_ready", bus.cmd_ready, 1'b1);
        exp_q.delete();
        slv_q.delete();
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        @(negedge pclk);
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid || bus.psel) seen++;
        end
        chk32("post_rst_no_activity", 32'(seen), 32'd0);
        @(posedge pclk);
        #1;
        drive(1'b0, 10'h0F3, 32'h0, 0, 32'h0123_4567, 1'b0, 32'h0123_4567, 1'b0, 1'b0);
        drain("post_rst_drain", 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_timer_cmd_master.md
# apb_timer_cmd_master

Upstream APB requester for the APB timer slave (`paddr[11:2]` register map, 32-bit data). It accepts register read/write commands through a valid/ready command port and buffers them in a small FIFO. It then issues each command as a compliant two-phase APB transfer with wait-state support and a wait-state watchdog. It returns one in-order response per command (`rdata`, error, timeout).

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 16: max consecutive ACCESS cycles with `pready` low before abort; 0 disables the watchdog.

- `pclk` in 1: APB clock; all state on rising edge.
- `presetn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 10: word address [11:2].
- `cmd_wdata` in 32: write data (ignored for reads).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` out 32: read data; 0 for writes and aborts.
- `rsp_err` out 1: `pslverr` seen, or timeout.
- `rsp_timeout` out 1: transfer aborted by the watchdog.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `paddr` out 10: APB address [11:2].
- `pwdata` out 32: APB write data.
- `prdata` in 32: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.
- `busy` out 1: FIFO non-empty, or state ≠ IDLE, or `rsp_valid`.

## Operation
- FIFO: `cmd_ready = !full`, combinational from the occupancy count.
  - No push when full. Push and pop in the same cycle keep the count unchanged.
  - A pushed entry is visible at the head on the next cycle; there is no bypass.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE → SETUP when FIFO is non-empty and the response slot is free (`!rsp_valid || rsp_ready`).
  - Pop the head.
  - Register `psel=1`, `penable=0`, `paddr`, `pwrite`, and `pwdata` (`pwdata`=0 for reads).
- SETUP → ACCESS unconditionally; `penable=1`.
- ACCESS with `pready=1`:
  - Load the response: `rsp_rdata` = `prdata` for reads, else 0; `rsp_err` = `pslverr`; `rsp_timeout` = 0.
  - Set `rsp_valid`.
  - Drive `psel=0`, `penable=0`, and go to IDLE.
- ACCESS with `pready=0`: hold all APB outputs stable and increment the wait counter.
  - When `TIMEOUT`≠0 and the counter reaches `TIMEOUT`, abort: `psel`/`penable`→0, response `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`, go to IDLE.
- At least one idle cycle (`psel=0`) always follows each transfer. Back-to-back transfers are SETUP, ACCESS, IDLE, SETUP, …
- Between transfers, `paddr`, `pwrite`, and `pwdata` hold their last values.
- Response register is single-entry.
  - It holds until `rsp_ready`.
  - New data may be loaded in the same cycle as a handshake.
  - Responses are returned in command order, exactly one per accepted command.
- `pslverr` is sampled only in ACCESS with `pready=1`.

## Timing
- Reset values: `psel`, `penable`, `pwrite` = 0; `paddr` = 0; `pwdata` = 0; `rsp_valid`, `rsp_err`, `rsp_timeout` = 0; `rsp_rdata` = 0; `busy` = 0; FIFO empty, so `cmd_ready` = 1. FSM = IDLE; wait counter = 0.
- Latency for a command accepted at edge 0, with FIFO empty and the response slot free:
  - `psel` high after edge 1.
  - `penable` high after edge 2.
  - With `pready`=1 in that cycle, `rsp_valid` high and `psel`=0 after edge 3.
  - Each wait state adds 1 cycle.
- Watchdog: after `TIMEOUT` ACCESS cycles with `pready` low, `psel`/`penable` drop on the next edge. `pready` rising in that same cycle wins, and the transfer completes normally.
- Counter width is `$clog2(TIMEOUT+1)`; it clears on entry to SETUP.
- Reset asserted mid-operation: all outputs go to reset values immediately, the FIFO empties, and in-flight and queued commands are discarded with no response.
- Response slot full and `rsp_ready` low: the FSM stalls in IDLE with `psel=0`, and the FIFO keeps accepting commands until full.

## Test plan
- Write `addr` 0x000, `data` 0x0000_0007, `pready` tied 1 → `psel` high 1 cycle with `penable`=0, then 1 cycle with `penable`=1 and `pwdata`=7; `rsp_valid` with `rsp_err`=0 and `rsp_rdata`=0.
- Read `addr` 0x001, slave inserts 3 wait states, then `prdata`=0xDEAD_BEEF → `paddr`, `pwrite`, `pwdata` stable for 4 ACCESS cycles; `rsp_rdata`=0xDEAD_BEEF.
- Push 5 commands with `DEPTH`=4 and `rsp_ready`=0 → `cmd_ready` low once full, no `psel` while `rsp_valid` is pending; releasing `rsp_ready` drains all 5 in order with an idle cycle between transfers.
- `pready` held 0 with `TIMEOUT`=16 → abort after 16 ACCESS cycles; response `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0; the next command proceeds normally.
- `pslverr`=1 with `pready`=1 on a write → `rsp_err`=1, `rsp_timeout`=0.
- `presetn` asserted during an ACCESS wait state with 2 commands queued → `psel`/`penable` drop asynchronously; after release, `busy`=0, `cmd_ready`=1, and no response is emitted.
